// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the iterative multiplier.
//   cnt_w()       - width of a counter that must hold values 0..width
//   mul_op_e      - M-extension multiply flavours
//   op_to_signs() - maps a multiply flavour to its {signed_a, signed_b} flags
package mul_pkg;

  typedef enum logic [1:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU
  } mul_op_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Returns {signed_a, signed_b}. MUL only consumes the low half, which is
  // identical for every sign combination, so it shares MULHU's flags.
  function automatic logic [1:0] op_to_signs(input mul_op_e op);
    logic [1:0] signs;
    unique case (op)
      MULH:    signs = 2'b11;
      MULHSU:  signs = 2'b10;
      default: signs = 2'b00;
    endcase
    return signs;
  endfunction

endpackage

// File: rtl/mul.sv
// mul: iterative radix-2 shift-add multiplier, one multiplier bit per cycle.
// Produces the full 2*DATA_WIDTH product; start/ready handshake matches the
// sequential divider.
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   multiplicand - operand A, sampled when start=1
//   multiplier   - operand B, sampled when start=1
//   signed_a     - A is two's complement, sampled with start
//   signed_b     - B is two's complement, sampled with start
//   start        - single-cycle launch pulse; restarts any operation in flight
//   product_lo   - product bits [DATA_WIDTH-1:0]
//   product_hi   - product bits [2*DATA_WIDTH-1:DATA_WIDTH]
//   ready        - idle and product outputs valid
// DATA_WIDTH must be >= 2.
module mul
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  input  logic                  signed_a,
  input  logic                  signed_b,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic                  ready
);

  localparam int              CW       = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);

  // acc_q carries one guard bit above the upper partial product so a signed
  // multiplicand's partial sums keep their sign.
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic                  sa_q, sb_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;

  logic [DATA_WIDTH+1:0] ext_a;
  logic [DATA_WIDTH+1:0] acc_x;
  logic [DATA_WIDTH+1:0] sum;
  logic                  last;

  // Step datapath. The sum is one bit wider than acc_q so the bit shifted in
  // at the top is the true sign of the sum, even when an unsigned add carries
  // out of the guard position.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path infers a latch.
  always_comb begin
    ext_a   = {{2{sa_q & mcand_q[DATA_WIDTH-1]}}, mcand_q};
    acc_x   = {acc_q[DATA_WIDTH], acc_q};
    last    = (count_q == LAST_CNT);
    sum     = acc_x;
    if (lo_q[0]) begin
      // The MSB of a two's complement multiplier weighs -2^(DATA_WIDTH-1),
      // so its partial product is subtracted.
      sum = (last && sb_q) ? acc_x - ext_a : acc_x + ext_a;
    end
    acc_d   = sum[DATA_WIDTH+1:1];
    lo_d    = {sum[0], lo_q[DATA_WIDTH-1:1]};
    count_d = count_q + 1'b1;
    ready_d = last;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else if (start) begin
      acc_q   <= '0;
      lo_q    <= multiplier;
      mcand_q <= multiplicand;
      sa_q    <= signed_a;
      sb_q    <= signed_b;
      count_q <= '0;
      ready_q <= 1'b0;
    end else if (!ready_q) begin
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign product_hi = acc_q[DATA_WIDTH-1:0];
  assign product_lo = lo_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_mul.sv
// tb_mul: self-checking bench for mul (DATA_WIDTH=32). Expected products are
// computed by a 66-bit signed reference multiply, queued at launch and
// compared when ready rises.
module tb_mul;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] multiplicand, multiplier;
  logic         signed_a, signed_b, start;
  logic [W-1:0] product_lo, product_hi;
  logic         ready;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    string          tag;
  } exp_t;

  exp_t sb_q[$];

  mul #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_a     (signed_a),
    .signed_b     (signed_b),
    .start        (start),
    .product_lo   (product_lo),
    .product_hi   (product_hi),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic sa, input logic sb);
    logic signed [2*W+1:0] ea, eb, p;
    ea = sa ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    eb = sb ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = ea * eb;
    return p[2*W-1:0];
  endfunction

  // Called at a negedge; start is seen by the next rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb, input string tag);
    exp_t e;
    multiplicand = a;
    multiplier   = b;
    signed_a     = sa;
    signed_b     = sb;
    start        = 1'b1;
    e.prod = ref_mul(a, b, sa, sb);
    e.tag  = tag;
    sb_q.push_back(e);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    signed_a     = 1'($urandom);
    signed_b     = 1'($urandom);
  endtask

  // Waits (bounded) for ready, optionally checks the busy length, then pops
  // and compares. Returns at the negedge where ready was first seen high.
  task automatic finish_op(input bit chk_lat, output logic [2*W-1:0] got);
    int   busy;
    exp_t e;
    busy = 0;
    while (!ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    got = {product_hi, product_lo};
    if (!ready) check("ready_timeout", 64'(ready), 64'(1));
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
    end else begin
      e = sb_q.pop_front();
      if (chk_lat) check({e.tag, "_latency"}, 64'(busy), 64'(W));
      check(e.tag, got, e.prod);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      4:       v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [2*W-1:0] got;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    signed_a     = 1'b0;
    signed_b     = 1'b0;

    #3;
    check("reset_ready", 64'(ready), 64'(1));
    check("reset_product", {product_hi, product_lo}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Unsigned maximum, with latency and hold
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "uu_max");
    finish_op(1'b1, got);
    check("uu_max_const", got, 64'hFFFF_FFFE_0000_0001);
    repeat (5) @(negedge clk);
    check("hold_ready", 64'(ready), 64'(1));
    check("hold_product", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);

    // Signed corners and mixed signs
    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "ss_minmin");
    finish_op(1'b1, got);
    check("ss_minmin_const", got, 64'h4000_0000_0000_0000);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "ss_m1m1");
    finish_op(1'b1, got);
    check("ss_m1m1_const", got, 64'h0000_0000_0000_0001);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "su_m1max");
    finish_op(1'b1, got);
    check("su_m1max_const", got, 64'hFFFF_FFFF_0000_0001);
    launch(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, "ss_7m3");
    finish_op(1'b1, got);
    check("ss_7m3_const", got, 64'hFFFF_FFFF_FFFF_FFEB);

    // Restart at busy cycle 10: the first operation is abandoned
    repeat (2) @(negedge clk);
    launch(32'd5, 32'd6, 1'b0, 1'b0, "abandoned");
    repeat (9) @(negedge clk);
    sb_q.delete();
    launch(32'd3, 32'd4, 1'b0, 1'b0, "restart");
    finish_op(1'b1, got);
    check("restart_const", got, 64'd12);

    // Back-to-back: second start in the cycle ready rises
    launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, "b2b_first");
    finish_op(1'b1, got);
    launch(32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 1'b1, "b2b_second");
    finish_op(1'b1, got);

    // Asynchronous reset between edges at busy cycle 17
    launch(32'hCAFE_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, "aborted");
    repeat (16) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(ready), 64'(1));
    check("async_rst_product", {product_hi, product_lo}, '0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    launch(32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, "post_reset");
    finish_op(1'b1, got);
    check("post_reset_const", got, 64'h0000_0001_2345_6780);

    // Random operands and sign flags, issued back-to-back
    for (int i = 0; i < 2000; i++) begin
      launch(pick(), pick(), 1'($urandom), 1'($urandom), "random");
      finish_op(1'b0, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
